// File: rtl/physics_pkg.sv
// rtl/physics_pkg.sv - shared constants, record sizing helpers and enums for the scene loader
package physics_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Bytes per sprite record: loc and velo words, then the mass, then one radius byte.
  function automatic int bps_f(input int width, input int dims);
    return 2 * dims * width / 8 + width / 16 + 1;
  endfunction

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
`ifdef SCENE_LOADER_CHKSUM_EN
    ST_CHECK = 2'd2,
`endif
    ST_DONE  = 2'd3
  } loader_state_e;

  typedef enum logic [1:0] {
    FLD_LOC  = 2'd0,
    FLD_VELO = 2'd1,
    FLD_MASS = 2'd2,
    FLD_RAD  = 2'd3
  } field_sel_e;

endpackage

// File: rtl/scene_field_decoder.sv
// rtl/scene_field_decoder.sv - maps a record byte offset to its field, axis and byte lane
module scene_field_decoder
  import physics_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DIMENSIONS = 2,
  localparam int BPS = bps_f(WIDTH, DIMENSIONS),
  localparam int CW  = idx_w(BPS),
  localparam int DW  = idx_w(DIMENSIONS),
  localparam int LW  = idx_w(WIDTH / 8)
) (
  input  logic [CW-1:0] byte_cnt_i,
  output field_sel_e    field_o,
  output logic [DW-1:0] dim_o,
  output logic [LW-1:0] lane_o
);

  localparam logic [CW-1:0] W8       = CW'(WIDTH / 8);
  localparam logic [CW-1:0] LOC_END  = CW'(DIMENSIONS * WIDTH / 8);
  localparam logic [CW-1:0] VELO_END = CW'(2 * DIMENSIONS * WIDTH / 8);
  localparam logic [CW-1:0] MASS_END = CW'(2 * DIMENSIONS * WIDTH / 8 + WIDTH / 16);

  logic [CW-1:0] rel;

  // Field boundaries are fixed by the record layout; rel is the offset inside the field group.
  always_comb begin
    field_o = FLD_RAD;
    rel     = '0;
    if (byte_cnt_i < LOC_END) begin
      field_o = FLD_LOC;
      rel     = byte_cnt_i;
    end else if (byte_cnt_i < VELO_END) begin
      field_o = FLD_VELO;
      rel     = byte_cnt_i - LOC_END;
    end else if (byte_cnt_i < MASS_END) begin
      field_o = FLD_MASS;
      rel     = byte_cnt_i - VELO_END;
    end
    dim_o  = DW'(rel / W8);
    lane_o = LW'(rel % W8);
  end

endmodule

// File: rtl/scene_loader.sv
// rtl/scene_loader.sv - byte-stream scene loader; SCENE_LOADER_CHKSUM_EN adds a trailing XOR checksum
module scene_loader
  import physics_pkg::*;
#(
  parameter int SPRITES    = 9,
  parameter int WIDTH      = 32,
  parameter int DIMENSIONS = 2
) (
  input  logic                              clk_162,
  input  logic                              rst_l,
  input  logic [7:0]                        in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [SPRITES*DIMENSIONS*WIDTH-1:0] init_locations,
  output logic [SPRITES*DIMENSIONS*WIDTH-1:0] init_velos,
  output logic [SPRITES*WIDTH/2-1:0]        masses,
  output logic [SPRITES*7-1:0]              radii,
  output logic                              data_ready,
  output logic                              busy,
  output logic                              load_error
);

  localparam int BPS = bps_f(WIDTH, DIMENSIONS);
  localparam int CW  = idx_w(BPS);
  localparam int SW  = idx_w(SPRITES);
  localparam int DW  = idx_w(DIMENSIONS);
  localparam int LW  = idx_w(WIDTH / 8);

  localparam logic [CW-1:0] LAST_BYTE = CW'(BPS - 1);
  localparam logic [SW-1:0] LAST_SPR  = SW'(SPRITES - 1);

  loader_state_e state_q, state_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [SW-1:0] spr_cnt_q, spr_cnt_d;
  logic          rdy, start, load_en, last_rec;

  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] loc_q, velo_q;
  logic [SPRITES-1:0][WIDTH/2-1:0]               mass_q;
  logic [SPRITES-1:0][6:0]                       rad_q;

  field_sel_e    dec_field;
  logic [DW-1:0] dec_dim;
  logic [LW-1:0] dec_lane;

`ifdef SCENE_LOADER_CHKSUM_EN
  logic [7:0] chk_q;
  logic       err_d, err_q;
`endif

  scene_field_decoder #(
    .WIDTH      (WIDTH),
    .DIMENSIONS (DIMENSIONS)
  ) u_dec (
    .byte_cnt_i (byte_cnt_q),
    .field_o    (dec_field),
    .dim_o      (dec_dim),
    .lane_o     (dec_lane)
  );

  assign last_rec = (byte_cnt_q == LAST_BYTE) && (spr_cnt_q == LAST_SPR);

  // Next-state and handshake decode; DONE is the only state that refuses bytes.
  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    start   = 1'b0;
    load_en = 1'b0;
`ifdef SCENE_LOADER_CHKSUM_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        rdy = 1'b1;
        if (in_valid && (in_data == SYNC_BYTE)) begin
          start   = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        rdy = 1'b1;
        if (in_valid) begin
          load_en = 1'b1;
          if (last_rec) begin
`ifdef SCENE_LOADER_CHKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef SCENE_LOADER_CHKSUM_EN
      ST_CHECK: begin
        rdy = 1'b1;
        if (in_valid) begin
          if (in_data == chk_q) begin
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte counter wraps per record and advances the sprite counter.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    spr_cnt_d  = spr_cnt_q;
    if (start) begin
      byte_cnt_d = '0;
      spr_cnt_d  = '0;
    end else if (load_en) begin
      if (byte_cnt_q == LAST_BYTE) begin
        byte_cnt_d = '0;
        spr_cnt_d  = spr_cnt_q + SW'(1);
      end else begin
        byte_cnt_d = byte_cnt_q + CW'(1);
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_162) begin
    if (!rst_l) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      spr_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      spr_cnt_q  <= spr_cnt_d;
    end
  end

  // Each payload byte lands straight in its field lane; no staging buffer.
  always_ff @(posedge clk_162) begin
    if (!rst_l) begin
      loc_q  <= '0;
      velo_q <= '0;
      mass_q <= '0;
      rad_q  <= '0;
    end else if (load_en) begin
      unique case (dec_field)
        FLD_LOC:  loc_q[spr_cnt_q][dec_dim][{dec_lane, 3'b000} +: 8]  <= in_data;
        FLD_VELO: velo_q[spr_cnt_q][dec_dim][{dec_lane, 3'b000} +: 8] <= in_data;
        FLD_MASS: mass_q[spr_cnt_q][{dec_lane, 3'b000} +: 8]          <= in_data;
        FLD_RAD:  rad_q[spr_cnt_q]                                    <= in_data[6:0];
        default: ;
      endcase
    end
  end

`ifdef SCENE_LOADER_CHKSUM_EN
  // Running XOR of payload bytes and the registered mismatch pulse.
  always_ff @(posedge clk_162) begin
    if (!rst_l) begin
      chk_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (start) begin
        chk_q <= '0;
      end else if (load_en) begin
        chk_q <= chk_q ^ in_data;
      end
    end
  end

  assign load_error = err_q;
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_CHECK);
`else
  assign load_error = 1'b0;
  assign busy       = (state_q == ST_LOAD);
`endif

  assign in_ready       = rdy & rst_l;
  assign data_ready     = (state_q == ST_DONE);
  assign init_locations = loc_q;
  assign init_velos     = velo_q;
  assign masses         = mass_q;
  assign radii          = rad_q;

endmodule

// File: tb/tb_scene_loader.sv
// tb/tb_scene_loader.sv - self-checking bench for scene_loader with a transaction-level model
`timescale 1ns/1ps
module tb_scene_loader;

  localparam int S     = 9;
  localparam int W     = 32;
  localparam int D     = 2;
  localparam int W8    = W / 8;
  localparam int BPS   = 2 * D * W8 + W / 16 + 1;
  localparam int TOTAL = S * BPS;
  localparam int VW    = S * D * W;
`ifdef SCENE_LOADER_CHKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk_162 = 1'b0;
  logic rst_l = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0;
  logic in_ready, data_ready, busy, load_error;
  logic [VW-1:0] init_locations, init_velos;
  logic [S*W/2-1:0] masses;
  logic [S*7-1:0] radii;

  scene_loader #(.SPRITES(S), .WIDTH(W), .DIMENSIONS(D)) dut (
    .clk_162        (clk_162),
    .rst_l          (rst_l),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .init_locations (init_locations),
    .init_velos     (init_velos),
    .masses         (masses),
    .radii          (radii),
    .data_ready     (data_ready),
    .busy           (busy),
    .load_error     (load_error)
  );

  always #3 clk_162 = ~clk_162;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [575:0] act, input logic [575:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         cyc = 0;
  bit         started = 1'b0;
  bit         m_busy = 1'b0, m_pulse = 1'b0, m_err = 1'b0;
  int         m_n = 0;
  int         sync_cyc = 0;
  logic [7:0] m_x = 8'h00;
  logic [7:0] m_img [TOTAL];

  initial begin : model
    bit xfer;
    forever begin
      @(posedge clk_162);
      cyc++;
      xfer = in_valid && rst_l && !m_pulse;
      if (!rst_l) begin
        started = 1'b1;
        m_busy = 1'b0; m_pulse = 1'b0; m_err = 1'b0; m_n = 0;
      end else begin
        m_pulse = 1'b0;
        m_err   = 1'b0;
        if (xfer) begin
          if (!m_busy) begin
            if (in_data == 8'hA5) begin
              m_busy = 1'b1; m_n = 0; m_x = 8'h00; sync_cyc = cyc;
            end
          end else if (m_n < TOTAL) begin
            m_img[m_n] = in_data;
            m_x = m_x ^ in_data;
            m_n++;
            if (m_n == TOTAL && !CHK) begin
              m_pulse = 1'b1; m_busy = 1'b0;
            end
          end else begin
            if (in_data == m_x) m_pulse = 1'b1;
            else m_err = 1'b1;
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int dut_dr_n = 0, dut_dr_cyc = 0, dut_err_n = 0;

  initial begin : compare
    logic [VW-1:0]    e_loc, e_vel;
    logic [S*W/2-1:0] e_mass;
    logic [S*7-1:0]   e_rad;
    forever begin
      @(negedge clk_162);
      if (started) begin
        check_bit("in_ready", in_ready, rst_l && !m_pulse);
        check_bit("busy", busy, m_busy);
        check_bit("data_ready", data_ready, m_pulse);
        check_bit("load_error", load_error, m_err);
        if (data_ready === 1'b1) begin dut_dr_n++; dut_dr_cyc = cyc; end
        if (load_error === 1'b1) dut_err_n++;
        if (m_pulse) begin
          e_loc = '0; e_vel = '0; e_mass = '0; e_rad = '0;
          for (int s = 0; s < S; s++) begin
            for (int d = 0; d < D; d++)
              for (int k = 0; k < W8; k++) begin
                e_loc[(s*D+d)*W + 8*k +: 8] = m_img[s*BPS + d*W8 + k];
                e_vel[(s*D+d)*W + 8*k +: 8] = m_img[s*BPS + (D+d)*W8 + k];
              end
            for (int k = 0; k < W/16; k++)
              e_mass[s*(W/2) + 8*k +: 8] = m_img[s*BPS + 2*D*W8 + k];
            e_rad[s*7 +: 7] = m_img[s*BPS + BPS-1][6:0];
          end
          check_vec("model_locations", 576'(init_locations), 576'(e_loc));
          check_vec("model_velos", 576'(init_velos), 576'(e_vel));
          check_vec("model_masses", 576'(masses), 576'(e_mass));
          check_vec("model_radii", 576'(radii), 576'(e_rad));
        end
      end
    end
  end

  // ---------------- scene construction and driving ----------------
  logic [W-1:0]   sc_loc [S][D];
  logic [W-1:0]   sc_vel [S][D];
  logic [W/2-1:0] sc_mass [S];
  logic [7:0]     sc_rad [S];
  logic [7:0]     frame [$];
  logic [7:0]     xsum;

  task automatic put(input logic [7:0] b);
    frame.push_back(b);
    xsum = xsum ^ b;
  endtask

  task automatic build_frame();
    frame.delete();
    frame.push_back(8'hA5);
    xsum = 8'h00;
    for (int s = 0; s < S; s++) begin
      for (int d = 0; d < D; d++) for (int k = 0; k < W8; k++) put(sc_loc[s][d][8*k +: 8]);
      for (int d = 0; d < D; d++) for (int k = 0; k < W8; k++) put(sc_vel[s][d][8*k +: 8]);
      for (int k = 0; k < W/16; k++) put(sc_mass[s][8*k +: 8]);
      put(sc_rad[s]);
    end
    if (CHK) frame.push_back(xsum);
  endtask

  task automatic scene_a();
    for (int s = 0; s < S; s++) begin
      for (int d = 0; d < D; d++) begin sc_loc[s][d] = '0; sc_vel[s][d] = '0; end
      sc_mass[s] = '0; sc_rad[s] = 8'h00;
    end
    sc_loc[0][0] = 32'h0001_0000;
    sc_loc[0][1] = 32'h0002_0000;
    sc_vel[0][0] = 32'hFFFF_FF00;
    sc_mass[0]   = 16'h0C00;
    sc_rad[0]    = 8'h85;
  endtask

  task automatic scene_rand();
    for (int s = 0; s < S; s++) begin
      for (int d = 0; d < D; d++) begin sc_loc[s][d] = $urandom; sc_vel[s][d] = $urandom; end
      sc_mass[s] = 16'($urandom);
      sc_rad[s]  = 8'($urandom);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      while ($urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        @(posedge clk_162); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk_162); #1;
      t++;
    end
    check_bit("handshake_ready", in_ready, 1'b1);
    @(posedge clk_162); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit gaps);
    for (int i = 0; i < n; i++) send_byte(frame[i], gaps);
  endtask

  task automatic settle();
    in_valid = 1'b0;
    repeat (4) @(posedge clk_162);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1);
  end

  initial begin : stim
    logic [VW-1:0]    sv_loc, sv_vel;
    logic [S*W/2-1:0] sv_mass;
    logic [S*7-1:0]   sv_rad;
    int d0, e0;

    rst_l = 1'b0;
    repeat (3) @(posedge clk_162);
    #1;
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_data_ready", data_ready, 1'b0);
    check_bit("rst_load_error", load_error, 1'b0);
    check_vec("rst_locations", 576'(init_locations), 576'(0));
    check_vec("rst_radii", 576'(radii), 576'(0));
    rst_l = 1'b1;
    #1;
    check_bit("ready_after_reset", in_ready, 1'b1);

    // Reference scene at full rate; the consumer samples data_ready 172 edges after the sync edge.
    scene_a(); build_frame();
    d0 = dut_dr_n;
    send_frame(frame.size(), 1'b0);
    settle();
    check_int("a_data_ready_count", dut_dr_n - d0, 1);
    check_int("a_latency", dut_dr_cyc + 1 - sync_cyc, CHK ? 173 : 172);
    check_vec("a_loc00", 576'(init_locations[31:0]), 576'(32'h0001_0000));
    check_vec("a_loc01", 576'(init_locations[63:32]), 576'(32'h0002_0000));
    check_vec("a_velo00", 576'(init_velos[31:0]), 576'(32'hFFFF_FF00));
    check_vec("a_mass0", 576'(masses[15:0]), 576'(16'h0C00));
    check_vec("a_radius0", 576'(radii[6:0]), 576'(7'h05));
    check_vec("a_loc_sprite1", 576'(init_locations[127:64]), 576'(0));

    // Junk ahead of the sync byte is swallowed without starting a frame.
    d0 = dut_dr_n;
    send_byte(8'h00, 1'b0);
    check_bit("junk0_busy", busy, 1'b0);
    send_byte(8'h13, 1'b0);
    check_bit("junk1_busy", busy, 1'b0);
    send_frame(frame.size(), 1'b0);
    settle();
    check_int("junk_data_ready_count", dut_dr_n - d0, 1);
    check_vec("junk_loc00", 576'(init_locations[31:0]), 576'(32'h0001_0000));

    // 0xA5 inside the payload is data: frame byte 5 is lane 0 of loc[0][1].
    scene_a(); sc_loc[0][1] = 32'h1234_56A5; build_frame();
    d0 = dut_dr_n;
    send_frame(frame.size(), 1'b0);
    settle();
    check_int("a5_data_ready_count", dut_dr_n - d0, 1);
    check_vec("a5_loc01_lane0", 576'(init_locations[39:32]), 576'(8'hA5));
    check_vec("a5_loc01", 576'(init_locations[63:32]), 576'(32'h1234_56A5));

    // Random scene, gap-free then with random valid gaps: identical arrays.
    scene_rand(); build_frame();
    send_frame(frame.size(), 1'b0);
    settle();
    sv_loc = init_locations; sv_vel = init_velos; sv_mass = masses; sv_rad = radii;
    scene_a(); build_frame();
    send_frame(frame.size(), 1'b0);
    settle();
    scene_rand(); build_frame();
    frame.delete();
    d0 = dut_dr_n;
    begin
      // regenerate the same random scene from the saved arrays
      for (int s = 0; s < S; s++) begin
        for (int d = 0; d < D; d++) begin
          sc_loc[s][d] = sv_loc[(s*D+d)*W +: W];
          sc_vel[s][d] = sv_vel[(s*D+d)*W +: W];
        end
        sc_mass[s] = sv_mass[s*(W/2) +: W/2];
        sc_rad[s]  = {1'b1, sv_rad[s*7 +: 7]};
      end
    end
    build_frame();
    send_frame(frame.size(), 1'b1);
    settle();
    check_int("gap_data_ready_count", dut_dr_n - d0, 1);
    check_vec("gap_locations", 576'(init_locations), 576'(sv_loc));
    check_vec("gap_velos", 576'(init_velos), 576'(sv_vel));
    check_vec("gap_masses", 576'(masses), 576'(sv_mass));
    check_vec("gap_radii", 576'(radii), 576'(sv_rad));

    // One-cycle reset after frame byte 100 drops the partial scene.
    scene_rand(); build_frame();
    d0 = dut_dr_n;
    send_frame(100, 1'b0);
    rst_l = 1'b0;
    @(posedge clk_162); #1;
    rst_l = 1'b1;
    check_vec("midrst_locations", 576'(init_locations), 576'(0));
    check_vec("midrst_velos", 576'(init_velos), 576'(0));
    check_vec("midrst_masses", 576'(masses), 576'(0));
    check_bit("midrst_busy", busy, 1'b0);
    settle();
    check_int("midrst_no_data_ready", dut_dr_n - d0, 0);
    scene_a(); build_frame();
    send_frame(frame.size(), 1'b0);
    settle();
    check_int("midrst_reload_count", dut_dr_n - d0, 1);
    check_vec("midrst_reload_loc00", 576'(init_locations[31:0]), 576'(32'h0001_0000));

`ifdef SCENE_LOADER_CHKSUM_EN
    // Corrupted checksum is rejected; the correct one is accepted.
    scene_a(); build_frame();
    frame[frame.size()-1] = frame[frame.size()-1] ^ 8'h01;
    d0 = dut_dr_n; e0 = dut_err_n;
    send_frame(frame.size(), 1'b0);
    settle();
    check_int("badsum_data_ready_count", dut_dr_n - d0, 0);
    check_int("badsum_error_count", dut_err_n - e0, 1);
    build_frame();
    d0 = dut_dr_n; e0 = dut_err_n;
    send_frame(frame.size(), 1'b0);
    settle();
    check_int("goodsum_data_ready_count", dut_dr_n - d0, 1);
    check_int("goodsum_error_count", dut_err_n - e0, 0);
`else
    e0 = dut_err_n;
    check_int("no_chksum_error_count", e0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
